// File: rtl/beta_pkg.sv
// rtl/beta_pkg.sv - shared widths, zero-register constant and write-back entry type
package beta_pkg;

  localparam int ADR_W  = 5;
  localparam int DATA_W = 32;
  localparam logic [ADR_W-1:0] ZERO_REG = 5'd31;

  typedef struct packed {
    logic              valid;
    logic [ADR_W-1:0]  adr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_queue.sv
// rtl/wb_queue.sv - in-order load-return FIFO with address-match invalidate and match vectors
module wb_queue
  import beta_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  wb_entry_t             push_entry_i,
  input  logic                  pop_i,
  input  logic                  inv_en_i,
  input  logic [ADR_W-1:0]      inv_adr_i,
  input  logic [ADR_W-1:0]      rd_adr1_i,
  input  logic [ADR_W-1:0]      rd_adr2_i,
  output wb_entry_t             head_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DEPTH-1:0]      match1_o,
  output logic [DEPTH-1:0]      match2_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  wb_entry_t         mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q;
  logic [PW-1:0]     rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic              do_push;
  logic              do_pop;
  logic              push_stale;

  assign full_o     = (count_q == CW'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign do_push    = push_i & ~full_o;
  assign do_pop     = pop_i & ~empty_o;
  // A same-cycle ALU write to the same register is younger than this load.
  assign push_stale = inv_en_i && (push_entry_i.adr == inv_adr_i);
  assign head_o     = mem_q[rd_ptr_q];

  // Storage, pointers and count; popped slots drop their valid bit so matches only see live entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (inv_en_i && (mem_q[i].adr == inv_adr_i)) mem_q[i].valid <= 1'b0;
      end
      if (do_pop) begin
        mem_q[rd_ptr_q].valid <= 1'b0;
        rd_ptr_q              <= rd_ptr_q + PW'(1);
      end
      if (do_push) begin
        mem_q[wr_ptr_q].valid <= push_entry_i.valid & ~push_stale;
        mem_q[wr_ptr_q].adr   <= push_entry_i.adr;
        mem_q[wr_ptr_q].data  <= push_entry_i.data;
        wr_ptr_q              <= wr_ptr_q + PW'(1);
      end
      if (do_push && !do_pop)      count_q <= count_q + CW'(1);
      else if (!do_push && do_pop) count_q <= count_q - CW'(1);
    end
  end

  // Per-entry pending-write matches against the two decode read addresses.
  always_comb begin
    match1_o = '0;
    match2_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match1_o[i] = mem_q[i].valid && (mem_q[i].adr == rd_adr1_i);
      match2_o[i] = mem_q[i].valid && (mem_q[i].adr == rd_adr2_i);
    end
  end

endmodule

// File: rtl/regfile_writeback.sv
// rtl/regfile_writeback.sv - merges ALU results and queued load returns onto the register-file write port; optional WB_BYPASS_EN forwarding
module regfile_writeback
  import beta_pkg::*;
#(
  parameter int MAdr  = 5,
  parameter int Mdata = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alu_valid,
  input  logic [MAdr-1:0]  alu_adr,
  input  logic [Mdata-1:0] alu_data,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [MAdr-1:0]  ld_adr,
  input  logic [Mdata-1:0] ld_data,
  output logic             wrtEnable,
  output logic [MAdr-1:0]  wrtAdr,
  output logic [Mdata-1:0] wrtData,
  input  logic [MAdr-1:0]  rdAdr1,
  input  logic [MAdr-1:0]  rdAdr2,
`ifdef WB_BYPASS_EN
  output logic [Mdata-1:0] fwd1_data,
  output logic [Mdata-1:0] fwd2_data,
`endif
  output logic             busy1,
  output logic             busy2
);

  logic             wrt_en_q,   wrt_en_d;
  logic [MAdr-1:0]  wrt_adr_q,  wrt_adr_d;
  logic [Mdata-1:0] wrt_data_q, wrt_data_d;

  logic             alu_wr;
  logic             q_pop;
  logic             q_push;
  logic             q_full;
  logic             q_empty;
  wb_entry_t        q_head;
  wb_entry_t        q_push_entry;
  logic [DEPTH-1:0] q_match1;
  logic [DEPTH-1:0] q_match2;
  logic             out_hit1;
  logic             out_hit2;

  assign alu_wr       = alu_valid && (alu_adr != ZERO_REG);
  assign ld_ready     = ~q_full;
  assign q_push       = ld_valid && ld_ready && (ld_adr != ZERO_REG);
  assign q_pop        = ~alu_wr & ~q_empty;
  assign q_push_entry = '{valid: 1'b1, adr: ld_adr, data: ld_data};

  wb_queue #(.DEPTH(DEPTH)) u_queue (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (q_push),
    .push_entry_i (q_push_entry),
    .pop_i        (q_pop),
    .inv_en_i     (alu_wr),
    .inv_adr_i    (alu_adr),
    .rd_adr1_i    (rdAdr1),
    .rd_adr2_i    (rdAdr2),
    .head_o       (q_head),
    .full_o       (q_full),
    .empty_o      (q_empty),
    .match1_o     (q_match1),
    .match2_o     (q_match2)
  );

  // Write select: ALU first, else the queue head (an invalidated head pops silently).
  always_comb begin
    wrt_en_d   = 1'b0;
    wrt_adr_d  = wrt_adr_q;
    wrt_data_d = wrt_data_q;
    if (alu_wr) begin
      wrt_en_d   = 1'b1;
      wrt_adr_d  = alu_adr;
      wrt_data_d = alu_data;
    end else if (q_pop && q_head.valid) begin
      wrt_en_d   = 1'b1;
      wrt_adr_d  = q_head.adr;
      wrt_data_d = q_head.data;
    end
  end

  // Registered write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrt_en_q   <= 1'b0;
      wrt_adr_q  <= '0;
      wrt_data_q <= '0;
    end else begin
      wrt_en_q   <= wrt_en_d;
      wrt_adr_q  <= wrt_adr_d;
      wrt_data_q <= wrt_data_d;
    end
  end

  assign wrtEnable = wrt_en_q;
  assign wrtAdr    = wrt_adr_q;
  assign wrtData   = wrt_data_q;

  assign out_hit1 = wrt_en_q && (wrt_adr_q == rdAdr1);
  assign out_hit2 = wrt_en_q && (wrt_adr_q == rdAdr2);

`ifdef WB_BYPASS_EN
  // The output-stage value is forwarded, so only queued writes stall decode.
  assign busy1     = (rdAdr1 != ZERO_REG) && (|q_match1);
  assign busy2     = (rdAdr2 != ZERO_REG) && (|q_match2);
  assign fwd1_data = out_hit1 ? wrt_data_q : '0;
  assign fwd2_data = out_hit2 ? wrt_data_q : '0;
`else
  assign busy1 = (rdAdr1 != ZERO_REG) && (out_hit1 || (|q_match1));
  assign busy2 = (rdAdr2 != ZERO_REG) && (out_hit2 || (|q_match2));
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// tb/tb_regfile_writeback.sv - directed self-checking bench for regfile_writeback
module tb_regfile_writeback;

  logic        clk;
  logic        rst_n;
  logic        alu_valid;
  logic [4:0]  alu_adr;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_adr;
  logic [31:0] ld_data;
  logic        wrtEnable;
  logic [4:0]  wrtAdr;
  logic [31:0] wrtData;
  logic [4:0]  rdAdr1;
  logic [4:0]  rdAdr2;
  logic        busy1;
  logic        busy2;
`ifdef WB_BYPASS_EN
  logic [31:0] fwd1_data;
  logic [31:0] fwd2_data;
  localparam logic OUT_BUSY = 1'b0;
`else
  localparam logic OUT_BUSY = 1'b1;
`endif

  int checks = 0;
  int errors = 0;

  regfile_writeback #(.MAdr(5), .Mdata(32), .DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_valid (alu_valid),
    .alu_adr   (alu_adr),
    .alu_data  (alu_data),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_adr    (ld_adr),
    .ld_data   (ld_data),
    .wrtEnable (wrtEnable),
    .wrtAdr    (wrtAdr),
    .wrtData   (wrtData),
    .rdAdr1    (rdAdr1),
    .rdAdr2    (rdAdr2),
`ifdef WB_BYPASS_EN
    .fwd1_data (fwd1_data),
    .fwd2_data (fwd2_data),
`endif
    .busy1     (busy1),
    .busy2     (busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_wr(input string tag, input logic [4:0] adr, input logic [31:0] data);
    check({tag, "_en"}, {31'd0, wrtEnable}, 32'd1);
    check({tag, "_adr"}, {27'd0, wrtAdr}, {27'd0, adr});
    check({tag, "_data"}, wrtData, data);
  endtask

  initial begin
    rst_n = 1'b0; alu_valid = 1'b0; alu_adr = '0; alu_data = '0;
    ld_valid = 1'b0; ld_adr = '0; ld_data = '0; rdAdr1 = '0; rdAdr2 = '0;
    step(); step();
    check("rst_en", {31'd0, wrtEnable}, 32'd0);
    check("rst_adr", {27'd0, wrtAdr}, 32'd0);
    check("rst_data", wrtData, 32'd0);
    check("rst_ready", {31'd0, ld_ready}, 32'd1);
    check("rst_busy1", {31'd0, busy1}, 32'd0);
    check("rst_busy2", {31'd0, busy2}, 32'd0);
    rst_n = 1'b1;

    // single load to r3: write two edges after acceptance
    rdAdr1 = 5'd3; ld_valid = 1'b1; ld_adr = 5'd3; ld_data = 32'hA5;
    #1 check("ld_ready_pre", {31'd0, ld_ready}, 32'd1);
    step(); ld_valid = 1'b0;
    check("ld_ready_post", {31'd0, ld_ready}, 32'd1);
    check("ld_en_early", {31'd0, wrtEnable}, 32'd0);
    check("ld_busy_q", {31'd0, busy1}, 32'd1);
    step();
    check_wr("ld_wr", 5'd3, 32'hA5);
    check("ld_busy_out", {31'd0, busy1}, {31'd0, OUT_BUSY});
    step();
    check("ld_idle_en", {31'd0, wrtEnable}, 32'd0);
    check("ld_idle_busy", {31'd0, busy1}, 32'd0);

    // ALU and load together: ALU first
    alu_valid = 1'b1; alu_adr = 5'd7; alu_data = 32'h11;
    ld_valid = 1'b1; ld_adr = 5'd4; ld_data = 32'h22;
    step(); alu_valid = 1'b0; ld_valid = 1'b0;
    check_wr("mix_alu", 5'd7, 32'h11);
    step();
    check_wr("mix_ld", 5'd4, 32'h22);
    step();
    check("mix_idle", {31'd0, wrtEnable}, 32'd0);

    // ALU starves the queue until it fills
    alu_adr = 5'd20;
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1'b1; alu_data = 32'(i);
      ld_valid = 1'b1; ld_adr = 5'(10 + i); ld_data = 32'(100 + i);
      check("fill_ready", {31'd0, ld_ready}, 32'd1);
      step();
      check_wr("fill_alu", 5'd20, 32'(i));
    end
    alu_valid = 1'b0; ld_adr = 5'd14; ld_data = 32'hEE;
    check("full_ready", {31'd0, ld_ready}, 32'd0);
    step(); ld_valid = 1'b0;
    check_wr("drain0", 5'd10, 32'd100);
    check("drain_ready", {31'd0, ld_ready}, 32'd1);
    for (int i = 1; i < 4; i++) begin
      step();
      check_wr("drain", 5'(10 + i), 32'(100 + i));
    end
    step();
    check("full_no_enq", {31'd0, wrtEnable}, 32'd0);

    // queued load overtaken by a younger ALU write to the same register
    rdAdr1 = 5'd5; ld_valid = 1'b1; ld_adr = 5'd5; ld_data = 32'h55;
    step(); ld_valid = 1'b0;
    alu_valid = 1'b1; alu_adr = 5'd5; alu_data = 32'h99;
    check("inv_busy_q", {31'd0, busy1}, 32'd1);
    step(); alu_valid = 1'b0;
    check_wr("inv_alu", 5'd5, 32'h99);
    check("inv_busy_out", {31'd0, busy1}, {31'd0, OUT_BUSY});
    step();
    check("inv_pop_en", {31'd0, wrtEnable}, 32'd0);
    check("inv_busy_clr", {31'd0, busy1}, 32'd0);

    // same-cycle same-address load is older and is dropped
    alu_valid = 1'b1; alu_adr = 5'd6; alu_data = 32'h66;
    ld_valid = 1'b1; ld_adr = 5'd6; ld_data = 32'h77;
    step(); alu_valid = 1'b0; ld_valid = 1'b0;
    check_wr("same_alu", 5'd6, 32'h66);
    step();
    check("same_no_ld", {31'd0, wrtEnable}, 32'd0);

    // r31 is never written nor reported busy
    alu_valid = 1'b1; alu_adr = 5'd31; alu_data = 32'h31;
    ld_valid = 1'b1; ld_adr = 5'd31; ld_data = 32'h13;
    rdAdr1 = 5'd31; rdAdr2 = 5'd31;
    step(); alu_valid = 1'b0; ld_valid = 1'b0;
    check("r31_en0", {31'd0, wrtEnable}, 32'd0);
    check("r31_busy1", {31'd0, busy1}, 32'd0);
    check("r31_busy2", {31'd0, busy2}, 32'd0);
    step();
    check("r31_en1", {31'd0, wrtEnable}, 32'd0);

    // reset with three queued loads
    rdAdr1 = 5'd0; rdAdr2 = 5'd1;
    alu_valid = 1'b1; alu_adr = 5'd20; alu_data = 32'h0;
    for (int i = 1; i <= 3; i++) begin
      ld_valid = 1'b1; ld_adr = 5'(i); ld_data = 32'(i);
      step();
    end
    ld_valid = 1'b0;
    check("rq_busy2", {31'd0, busy2}, 32'd1);
    check("rq_en", {31'd0, wrtEnable}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rq_rst_en", {31'd0, wrtEnable}, 32'd0);
    check("rq_rst_adr", {27'd0, wrtAdr}, 32'd0);
    check("rq_rst_ready", {31'd0, ld_ready}, 32'd1);
    check("rq_rst_busy2", {31'd0, busy2}, 32'd0);
    alu_valid = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("rq_after_en", {31'd0, wrtEnable}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_writeback.md
# regfile_writeback

Write-side initiator for the Beta register file. Merges single-cycle ALU results and variable-latency load returns into the register file's single synchronous write port: `wrtAdr`, `wrtEnable`, `wrtData`. Buffers load returns in a small in-order queue. Reports per-read-port busy flags so the decode stage can stall on pending writes.

## Interface
Parameters:
- MAdr, 5, register address width
- Mdata, 32, data width
- DEPTH, 4, load-return queue depth (power of 2, ≥2)

Ports:
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  asynchronous, active-low reset
- alu_valid  in  1  ALU result present this cycle (no backpressure)
- alu_adr  in  MAdr  ALU destination register
- alu_data  in  Mdata  ALU result
- ld_valid  in  1  load return offered
- ld_ready  out  1  load return accepted when ld_valid & ld_ready
- ld_adr  in  MAdr  load destination register
- ld_data  in  Mdata  load data
- wrtEnable  out  1  register file write enable (registered)
- wrtAdr  out  MAdr  register file write address (registered)
- wrtData  out  Mdata  register file write data (registered)
- rdAdr1, rdAdr2  in  MAdr  decode-stage read addresses
- busy1, busy2  out  1  a write to rdAdrN is pending
- (WB_BYPASS_EN only) fwd1_data, fwd2_data  out  Mdata  forwarded value

## Operation
- The queue is an in-order FIFO of {valid, adr, data}, DEPTH entries, with a count register.
- ld_ready = (count != DEPTH). It is combinational from registered state. There is no enqueue when full, even if a pop happens in the same cycle.
- A load accepted with ld_adr == 31 is discarded and not enqueued. R31 is never written.
- Write-select each cycle, in priority order:
  - alu_valid & alu_adr != 31: write the ALU result.
  - Otherwise, if count != 0: pop the head. Write it only if the head's valid bit is set; a popped invalid entry produces no write.
  - Otherwise: no write.
- The ALU never pops the queue.
- When alu_valid & alu_adr != 31, every queued entry whose adr == alu_adr has its valid bit cleared in that cycle, because the ALU result is younger.
- A load accepted in the same cycle with the same address counts as older. It is enqueued already invalid.
- busyN is 1 when rdAdrN != 31 and either:
  - the output stage holds wrtEnable=1 with wrtAdr == rdAdrN, or
  - any valid queue entry has adr == rdAdrN.
- busyN is combinational from registered state and rdAdrN only.
- Reset values: wrtEnable=0, wrtAdr=0, wrtData=0, count=0, all valid bits 0. Outputs after reset: ld_ready=1, busy1=busy2=0.
- Reset asserted mid-operation drops all queued entries and any pending write.

## Timing
- ALU result: the write port is driven one cycle after alu_valid, and the register file updates on the following edge.
- Load return: minimum two cycles from acceptance to wrtEnable. It is enqueued on edge N, popped and registered on edge N+1, and longer if ALU writes intervene.
- Continuous alu_valid starves the queue. The decode stage guarantees a bubble within DEPTH cycles of any load issue.
- Queue pointers wrap modulo DEPTH. count ranges 0..DEPTH.

## Configuration
- WB_BYPASS_EN defined:
  - fwd1_data and fwd2_data exist.
  - When the output stage matches rdAdrN, fwdN_data = wrtData, and busyN is driven only by queue matches.
  - Otherwise fwdN_data = 0.
- WB_BYPASS_EN undefined: the fwd ports are absent, and busyN follows the rule given in Operation.

## Structure
- Shared package beta_pkg:
  - ADR_W=5, DATA_W=32, ZERO_REG=5'd31.
  - Typedef wb_entry_t {valid, adr, data}.
- One sub-module, wb_queue: the FIFO with per-entry address-match invalidate and a match-vector output for the busy logic.

## Test plan
- Reset, then a load {adr 3, data 0xA5} → ld_ready=1 throughout; wrtEnable=1, wrtAdr=3, wrtData=0xA5 two cycles after acceptance; busy for rdAdr1=3 during that window.
- alu {adr 7, 0x11} and load {adr 4, 0x22} in the same cycle → ALU writes r7 first, then r4 on the next cycle.
- alu_valid held high for 4 cycles with 4 loads offered → ld_ready=0 after the 4th accept; no writes to load targets until the ALU idles.
- Load {adr 5} queued, then alu {adr 5, 0x99} → r5 receives 0x99; the popped load produces no write; busy for 5 clears after the ALU write stage.
- Load to adr 31 and alu to adr 31 → never wrtEnable; busy never set for rdAdr 31.
- Reset asserted with 3 queued entries → wrtEnable=0 immediately; count=0; no write after release.
